// File: rtl/speed_ctrl.sv
// Game speed controller: debounced up/down buttons select the divider rate,
// and a two-state tick FSM turns the divided game clock into step pulses.
module speed_ctrl #(
  parameter int         DEB_CYCLES = 1_000_000,
  parameter logic [1:0] RESET_RATE = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        pause,
  input  logic        clk_game,
  output logic [1:0]  clk_rate,
  output logic        step,
  output logic [15:0] step_cnt,
  output logic        rate_changed
);

  localparam int            CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam int            BTN_UP  = 0;
  localparam int            BTN_DN  = 1;

  typedef enum logic {
    LOW,
    HIGH
  } tick_state_e;

  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    acc_q;
  logic [1:0]    press_q;
  logic [CW-1:0] cnt_q [2];

  logic [1:0]    rate_d, rate_q;
  logic          rate_changed_q;

  tick_state_e   state_q;
  logic          step_q;
  logic [15:0]   step_cnt_q;

  assign btn_raw = {btn_down, btn_up};

  // Synchronizer plus debouncer for both buttons; press_q is a one-cycle
  // pulse on each accepted 0->1 transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      press_q <= '0;
      // NOTE: the counter array sits in flops, not RAM, so it can and must be
      // reset; otherwise a mid-debounce reset could leave a stale count behind.
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2_q take the old sync1_q,
      // giving a true two-flop chain regardless of statement order.
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == acc_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          acc_q[i]   <= sync2_q[i];
          press_q[i] <= sync2_q[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rate_d and no latch is inferred.
    rate_d = rate_q;
    unique case ({press_q[BTN_DN], press_q[BTN_UP]})
      2'b01:   if (rate_q != 2'b00) rate_d = rate_q - 2'b01;
      2'b10:   if (rate_q != 2'b11) rate_d = rate_q + 2'b01;
      default: rate_d = rate_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q         <= RESET_RATE;
      rate_changed_q <= 1'b0;
    end else begin
      rate_q         <= rate_d;
      rate_changed_q <= (rate_d != rate_q);
    end
  end

  // Tick FSM: a rising edge of the sampled game clock issues one step unless
  // paused, in which case that edge is dropped but the level is still tracked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOW;
      step_q     <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      step_q <= 1'b0;
      unique case (state_q)
        LOW: begin
          if (clk_game) begin
            state_q <= HIGH;
            if (!pause) begin
              step_q     <= 1'b1;
              step_cnt_q <= step_cnt_q + 16'd1;
            end
          end
        end
        HIGH: begin
          if (!clk_game) state_q <= LOW;
        end
        default: state_q <= LOW;
      endcase
    end
  end

  assign clk_rate     = rate_q;
  assign rate_changed = rate_changed_q;
  assign step         = step_q;
  assign step_cnt     = step_cnt_q;

endmodule

// File: tb/tb_speed_ctrl.sv
// Self-checking bench for speed_ctrl: a cycle model built from the behavioural
// rules is compared every cycle, plus directed scenarios with literal results.
module tb_speed_ctrl;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        pause = 1'b0;
  logic        clk_game = 1'b0;
  logic [1:0]  clk_rate;
  logic        step;
  logic [15:0] step_cnt;
  logic        rate_changed;

  speed_ctrl #(
    .DEB_CYCLES(DEB),
    .RESET_RATE(2'b10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .pause       (pause),
    .clk_game    (clk_game),
    .clk_rate    (clk_rate),
    .step        (step),
    .step_cnt    (step_cnt),
    .rate_changed(rate_changed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a button level is accepted once the synchronized level has
  // disagreed with it for the last DEB samples in a row.
  function automatic logic [1:0] next_rate(input logic [1:0] r, input logic [1:0] p);
    int v;
    v = int'(r);
    if (p == 2'b01) v = (v > 0) ? v - 1 : 0;
    if (p == 2'b10) v = (v < 3) ? v + 1 : 3;
    return v[1:0];
  endfunction

  logic [1:0]     m_s1, m_s2, m_acc, m_press;
  logic [DEB-1:0] m_hist [2];
  logic [1:0]     m_rate;
  logic           m_rc, m_prev, m_step;
  logic [15:0]    m_cnt;
  logic           m_load = 1'b0;
  logic           cmp_en = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_acc <= '0; m_press <= '0;
      m_hist[0] <= '0; m_hist[1] <= '0;
      m_rate <= 2'b10; m_rc <= 1'b0;
      m_prev <= 1'b0; m_step <= 1'b0; m_cnt <= '0;
    end else begin
      m_s1 <= {btn_down, btn_up};
      m_s2 <= m_s1;
      for (int i = 0; i < 2; i++) begin
        m_hist[i]  <= {m_hist[i][DEB-2:0], m_s2[i]};
        m_press[i] <= 1'b0;
        if ({m_hist[i][DEB-2:0], m_s2[i]} == {DEB{~m_acc[i]}}) begin
          m_acc[i]   <= ~m_acc[i];
          m_press[i] <= ~m_acc[i];
        end
      end
      m_rate <= next_rate(m_rate, m_press);
      m_rc   <= (next_rate(m_rate, m_press) != m_rate);
      m_step <= clk_game && !m_prev && !pause;
      if (clk_game && !m_prev && !pause) m_cnt <= m_cnt + 16'd1;
      m_prev <= clk_game;
      if (m_load) m_cnt <= 16'hFFFF;
    end
  end

  int rc_total   = 0;
  int step_total = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_clk_rate", 32'(clk_rate), 32'(m_rate));
      check("cyc_rate_changed", 32'(rate_changed), 32'(m_rc));
      check("cyc_step", 32'(step), 32'(m_step));
      check("cyc_step_cnt", 32'(step_cnt), 32'(m_cnt));
    end
    if (rate_changed) rc_total <= rc_total + 1;
    if (step) step_total <= step_total + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; clk_game = 1'b0; pause = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  logic [1:0] s3_exp [3];
  int base, lat;

  initial begin
    s3_exp[0] = 2'b01; s3_exp[1] = 2'b00; s3_exp[2] = 2'b00;

    do_reset();
    check("reset_clk_rate", 32'(clk_rate), 32'h2);
    check("reset_step", 32'(step), 32'h0);
    check("reset_step_cnt", 32'(step_cnt), 32'h0);
    check("reset_rate_changed", 32'(rate_changed), 32'h0);

    // Scenario 1: single held up press
    base = rc_total;
    btn_up = 1'b1;
    lat = 0;
    while (clk_rate == 2'b10 && lat < 12) begin
      tick(1);
      lat++;
    end
    check("s1_latency_6_to_8", 32'(lat >= 6 && lat <= 8), 32'h1);
    tick(4);
    btn_up = 1'b0;
    tick(8);
    check("s1_clk_rate", 32'(clk_rate), 32'h1);
    check("s1_rc_pulses", 32'(rc_total - base), 32'h1);

    // Scenario 2: bouncing down button never accepted
    do_reset();
    base = rc_total;
    for (int k = 0; k < 10; k++) begin
      btn_down = ~btn_down;
      tick(2);
    end
    btn_down = 1'b0;
    tick(8);
    check("s2_clk_rate", 32'(clk_rate), 32'h2);
    check("s2_rc_pulses", 32'(rc_total - base), 32'h0);

    // Scenario 3: three clean up presses saturate at 00
    do_reset();
    base = rc_total;
    for (int k = 0; k < 3; k++) begin
      btn_up = 1'b1;
      tick(10);
      check("s3_clk_rate", 32'(clk_rate), 32'(s3_exp[k]));
      btn_up = 1'b0;
      tick(10);
    end
    check("s3_rc_pulses", 32'(rc_total - base), 32'h2);

    // Scenario 4: simultaneous presses cancel
    do_reset();
    base = rc_total;
    btn_up = 1'b1; btn_down = 1'b1;
    tick(12);
    check("s4_clk_rate", 32'(clk_rate), 32'h2);
    check("s4_rc_pulses", 32'(rc_total - base), 32'h0);
    btn_up = 1'b0; btn_down = 1'b0;
    tick(10);

    // Scenario 5: four game-clock periods, then the same while paused
    do_reset();
    base = step_total;
    for (int k = 0; k < 4; k++) begin
      clk_game = 1'b1;
      tick(1);
      if (k == 0) check("s5_step_latency", 32'(step), 32'h1);
      tick(7);
      clk_game = 1'b0;
      tick(8);
    end
    check("s5_steps", 32'(step_total - base), 32'h4);
    check("s5_step_cnt", 32'(step_cnt), 32'h4);
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      clk_game = 1'b1;
      tick(8);
      clk_game = 1'b0;
      tick(8);
    end
    pause = 1'b0;
    check("s5_paused_steps", 32'(step_total - base), 32'h4);
    check("s5_paused_step_cnt", 32'(step_cnt), 32'h4);

    // Reset released with clk_game already high gives one step
    rst_n = 1'b0; clk_game = 1'b1;
    tick(2);
    base = step_total;
    rst_n = 1'b1;
    tick(4);
    check("rel_high_steps", 32'(step_total - base), 32'h1);
    clk_game = 1'b0;
    tick(2);

    // Scenario 6: wrap of step_cnt from FFFF
    cmp_en = 1'b0;
    force dut.step_cnt_q = 16'hFFFF;
    m_load = 1'b1;
    tick(1);
    m_load = 1'b0;
    release dut.step_cnt_q;
    cmp_en = 1'b1;
    check("s6_preload", 32'(step_cnt), 32'hFFFF);
    clk_game = 1'b1;
    tick(1);
    check("s6_wrap_step", 32'(step), 32'h1);
    check("s6_wrap_cnt", 32'(step_cnt), 32'h0);
    tick(2);
    clk_game = 1'b0;
    tick(2);
    clk_game = 1'b1;
    tick(2);
    clk_game = 1'b0;
    check("s6_cnt_after", 32'(step_cnt), 32'h1);

    // Move rate off its reset value, then reset in the middle of a debounce
    btn_down = 1'b1;
    tick(10);
    btn_down = 1'b0;
    tick(10);
    check("s6_rate_before", 32'(clk_rate), 32'h3);
    btn_up = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("s6_async_clk_rate", 32'(clk_rate), 32'h2);
    check("s6_async_step_cnt", 32'(step_cnt), 32'h0);
    check("s6_async_step", 32'(step), 32'h0);
    check("s6_async_rc", 32'(rate_changed), 32'h0);
    btn_up = 1'b0;
    tick(2);
    base = rc_total;
    rst_n = 1'b1;
    tick(12);
    check("s6_no_residual_rc", 32'(rc_total - base), 32'h0);
    check("s6_no_residual_rate", 32'(clk_rate), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
